// File: rtl/prog_fsm_table_if.sv
// Programming, run-control and status bundle for prog_fsm_table.
// The master drives the controls and the slave (the controller) returns state and status.
interface prog_fsm_table_if #(
    parameter int STATE_WIDTH = 3,
    parameter int IN_WIDTH    = 4,
    parameter int OUT_WIDTH   = 8,
    parameter int DATA_WIDTH  = 8
);
    logic                   prog_enable;
    logic                   prog_advance;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [IN_WIDTH-1:0]    in;
    logic                   step;
    logic [STATE_WIDTH-1:0] state;
    logic [OUT_WIDTH-1:0]   out;
    logic                   loaded;
    logic                   overflow;
    logic                   fault;

    modport master (
        output prog_enable, prog_advance, data_in, in, step,
        input  state, out, loaded, overflow, fault
    );

    modport slave (
        input  prog_enable, prog_advance, data_in, in, step,
        output state, out, loaded, overflow, fault
    );
endinterface

// File: rtl/prog_fsm_table.sv
// Runtime-programmable Moore machine: serial word stream loads start state,
// per-state output words and transition targets; then one transition per step.
module prog_fsm_table #(
    parameter int STATE_COUNT = 8,
    parameter int IN_WIDTH    = 4,
    parameter int OUT_WIDTH   = 8,
    parameter int DATA_WIDTH  = 8
) (
    input  logic             clock,
    input  logic             reset,
    prog_fsm_table_if.slave  bus
);
    localparam int STATE_WIDTH = (STATE_COUNT > 1) ? $clog2(STATE_COUNT) : 1;
    localparam int SYMS        = 1 << IN_WIDTH;
    localparam int STRIDE      = 1 + SYMS;
    localparam int TOTAL       = 1 + STATE_COUNT * STRIDE;
    localparam int PW          = $clog2(TOTAL + 1);
    localparam int KW          = IN_WIDTH + 1;

    localparam logic [PW-1:0]          LAST    = PW'(TOTAL);
    localparam logic [PW-1:0]          FINAL   = PW'(TOTAL - 1);
    localparam logic [KW-1:0]          KMAX    = KW'(SYMS);
    localparam logic [STATE_WIDTH:0]   COUNT_V = (STATE_WIDTH + 1)'(STATE_COUNT);

    logic [STATE_WIDTH-1:0] cur_state;
    logic [STATE_WIDTH-1:0] start;
    logic [PW-1:0]          ptr;
    logic [STATE_WIDTH-1:0] wr_s;
    logic [KW-1:0]          wr_k;
    logic                   prev_en;
    logic                   loaded;
    logic                   overflow;
    logic                   fault;

    logic [OUT_WIDTH-1:0]   out_tab  [STATE_COUNT];
    logic [STATE_WIDTH-1:0] next_tab [STATE_COUNT][SYMS];

    logic                   write;
    logic                   rise;
    logic                   cur_ok;
    logic                   target_ok;
    logic [STATE_WIDTH-1:0] target;
    logic [OUT_WIDTH-1:0]   out_word;
    logic [IN_WIDTH-1:0]    sym;

    assign write  = bus.prog_enable & bus.prog_advance & (ptr != LAST);
    assign rise   = bus.prog_enable & ~prev_en;
    assign cur_ok = {1'b0, cur_state} < COUNT_V;
    assign sym    = wr_k[IN_WIDTH-1:0] - 1'b1;

    // Table lookup for the current state; an unreachable state index reads as zero.
    always_comb begin
        target    = '0;
        out_word  = '0;
        if (cur_ok) begin
            target   = next_tab[cur_state][bus.in];
            out_word = out_tab[cur_state];
        end
        target_ok = cur_ok && ({1'b0, target} < COUNT_V);
    end

    // Control: stream pointer, start register, status flags and the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= '0;
            start     <= '0;
            ptr       <= '0;
            wr_s      <= '0;
            wr_k      <= '0;
            prev_en   <= 1'b0;
            loaded    <= 1'b0;
            overflow  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            prev_en <= bus.prog_enable;
            if (bus.prog_enable) begin
                cur_state <= start;
                if (rise) begin
                    loaded   <= 1'b0;
                    overflow <= 1'b0;
                    fault    <= 1'b0;
                end
                if (bus.prog_advance) begin
                    if (write) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == FINAL) begin
                            loaded <= 1'b1;
                        end
                        if (ptr == '0) begin
                            start <= bus.data_in[STATE_WIDTH-1:0];
                        end else if (wr_k == KMAX) begin
                            wr_k <= '0;
                            wr_s <= wr_s + 1'b1;
                        end else begin
                            wr_k <= wr_k + 1'b1;
                        end
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end else begin
                ptr  <= '0;
                wr_s <= '0;
                wr_k <= '0;
                if (bus.step) begin
                    if (target_ok) begin
                        cur_state <= target;
                    end else begin
                        cur_state <= start;
                        fault     <= 1'b1;
                    end
                end
            end
        end
    end

    // Table storage: word 0 is the start state, then per state one output
    // word followed by one target per input symbol.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < STATE_COUNT; s++) begin
                out_tab[s] <= '0;
                for (int i = 0; i < SYMS; i++) begin
                    next_tab[s][i] <= '0;
                end
            end
        end else if (write && (ptr != '0)) begin
            if (wr_k == '0) begin
                out_tab[wr_s] <= bus.data_in[OUT_WIDTH-1:0];
            end else begin
                next_tab[wr_s][sym] <= bus.data_in[STATE_WIDTH-1:0];
            end
        end
    end

    assign bus.state    = cur_state;
    assign bus.out      = out_word;
    assign bus.loaded   = loaded;
    assign bus.overflow = overflow;
    assign bus.fault    = fault;
endmodule

// File: tb/tb_prog_fsm_table.sv
// Testbench for prog_fsm_table: an 8-state instance checked against a
// stream-level reference model, plus a 5-state instance for target faults.
module tb_prog_fsm_table;
    localparam int N   = 8;
    localparam int STR = 17;
    localparam int TOT = 1 + N * STR;

    logic clock = 1'b0;
    logic r0;
    logic r1;

    always #5 clock = ~clock;

    prog_fsm_table_if #(.STATE_WIDTH(3)) b0 ();
    prog_fsm_table_if #(.STATE_WIDTH(3)) b1 ();

    prog_fsm_table #(.STATE_COUNT(8)) u0 (.clock(clock), .reset(r0), .bus(b0));
    prog_fsm_table #(.STATE_COUNT(5)) u1 (.clock(clock), .reset(r1), .bus(b1));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: flat word stream plus flags
    int unsigned mem [TOT];
    int  wptr;
    bit  m_loaded, m_ovf, m_fault, m_prev;
    int  m_state;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int st;
        int nx;
        if (r0) begin
            foreach (mem[k]) mem[k] = 0;
            wptr = 0; m_loaded = 0; m_ovf = 0; m_fault = 0;
            m_prev = 0; m_state = 0;
        end else begin
            if (b0.prog_enable) begin
                st = int'(mem[0] & 7);
                if (!m_prev) begin
                    m_loaded = 0; m_ovf = 0; m_fault = 0;
                end
                if (b0.prog_advance) begin
                    if (wptr < TOT) begin
                        mem[wptr] = b0.data_in;
                        wptr++;
                        if (wptr == TOT) m_loaded = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
                m_state = st;
            end else begin
                wptr = 0;
                if (b0.step) begin
                    nx = int'(mem[1 + m_state * STR + 1 + int'(b0.in)] & 7);
                    if (nx < N) m_state = nx;
                    else begin
                        m_state = int'(mem[0] & 7);
                        m_fault = 1;
                    end
                end
            end
            m_prev = b0.prog_enable;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clock);
        #1;
        chk("state", b0.state, m_state);
        chk("out", b0.out, mem[1 + m_state * STR] & 8'hFF);
        chk("loaded", b0.loaded, m_loaded);
        chk("overflow", b0.overflow, m_ovf);
        chk("fault", b0.fault, m_fault);
    endtask

    task automatic idle0();
        b0.prog_enable = 0; b0.prog_advance = 0; b0.step = 0;
        b0.data_in = 0; b0.in = 0;
    endtask

    task automatic load0(input int unsigned q [$]);
        b0.prog_enable = 1; b0.step = 0;
        foreach (q[k]) begin
            b0.prog_advance = 1;
            b0.data_in = 8'(q[k]);
            tick();
        end
        b0.prog_advance = 0;
    endtask

    initial begin
        int unsigned q [$];
        int seq [6];
        int seq1 [4];
        int flt1 [4];
        seq  = '{3, 4, 5, 6, 7, 0};
        seq1 = '{4, 0, 1, 3};
        flt1 = '{0, 0, 0, 1};
        idle0();
        b1.prog_enable = 0; b1.prog_advance = 0; b1.step = 0;
        b1.data_in = 0; b1.in = 0;

        // reset with random inputs
        r0 = 1; r1 = 1;
        for (int k = 0; k < 2; k++) begin
            b0.prog_enable = 1'($urandom); b0.prog_advance = 1'($urandom);
            b0.data_in = 8'($urandom); b0.in = 4'($urandom);
            b0.step = 1'($urandom);
            tick();
        end
        r0 = 0; r1 = 0;
        idle0();
        chk("rst_state", b0.state, 0);
        chk("rst_out", b0.out, 0);
        chk("rst_flags", {b0.loaded, b0.overflow, b0.fault}, 0);
        chk("rst1_flags", {b1.loaded, b1.overflow, b1.fault}, 0);
        for (int k = 0; k < 4; k++) begin
            b0.step = 1; b0.in = 4'($urandom);
            tick();
            chk("rst_table", {b0.state, b0.out}, 0);
        end
        b0.step = 0;

        // counter FSM
        q = {};
        q.push_back(2 | ($urandom & 8'hF8));
        for (int s = 0; s < 8; s++) begin
            q.push_back(8'hA0 + s);
            for (int i = 0; i < 16; i++)
                q.push_back(((s + 1) % 8) | ($urandom & 8'hF8));
        end
        load0(q);
        chk("cnt_loaded", b0.loaded, 1);
        b0.prog_enable = 0;
        tick();
        chk("cnt_start_out", b0.out, 8'hA2);
        for (int j = 0; j < 6; j++) begin
            b0.step = 1; b0.in = 4'($urandom);
            tick();
            chk("cnt_seq", b0.state, seq[j]);
        end
        chk("cnt_end_out", b0.out, 8'hA0);

        // step gating
        b0.step = 0;
        for (int j = 0; j < 10; j++) begin
            b0.in = 4'($urandom);
            tick();
            chk("gate_hold", b0.state, 0);
        end

        // programming wins over step
        b0.prog_enable = 1; b0.step = 1;
        tick();
        chk("prog_wins", b0.state, 2);
        idle0();
        tick();

        // input-dependent branch
        q = {};
        q.push_back(0);
        for (int s = 0; s < 8; s++) begin
            q.push_back($urandom & 8'hFF);
            for (int i = 0; i < 16; i++)
                q.push_back((s == 0 && i == 5) ? 6 : 0);
        end
        load0(q);
        idle0();
        tick();
        b0.step = 1; b0.in = 4;
        tick();
        chk("branch_in4", b0.state, 0);
        b0.in = 5;
        tick();
        chk("branch_in5", b0.state, 6);
        idle0();

        // overflow: 140 words
        b0.prog_enable = 1;
        for (int k = 0; k < 140; k++) begin
            b0.prog_advance = 1; b0.data_in = 8'($urandom);
            tick();
            if (k == 136) chk("ovf_loaded137", {b0.loaded, b0.overflow}, 2'b10);
            if (k == 137) chk("ovf_first_extra", b0.overflow, 1);
        end
        idle0();
        tick();
        for (int k = 0; k < 30; k++) begin
            b0.step = 1'($urandom); b0.in = 4'($urandom);
            tick();
        end
        idle0();
        b0.prog_enable = 1;
        tick();
        chk("reenter_clear", {b0.loaded, b0.overflow}, 0);
        idle0();
        tick();

        // random program and random run
        q = {};
        for (int k = 0; k < TOT; k++) q.push_back($urandom & 8'hFF);
        load0(q);
        idle0();
        for (int k = 0; k < 300; k++) begin
            b0.prog_enable = ($urandom_range(0, 15) == 0);
            b0.step = 1'($urandom); b0.in = 4'($urandom);
            tick();
        end
        idle0();
        tick();

        // mid-stream reset
        b0.prog_enable = 1;
        for (int k = 0; k < 40; k++) begin
            b0.prog_advance = 1; b0.data_in = 8'($urandom | 1);
            tick();
        end
        idle0();
        r0 = 1;
        tick();
        r0 = 0;
        tick();
        chk("midrst_loaded", b0.loaded, 0);
        for (int k = 0; k < 20; k++) begin
            b0.step = 1; b0.in = 4'($urandom);
            tick();
            chk("midrst_table", {b0.state, b0.out}, 0);
        end
        idle0();

        // 5-state instance: out-of-range target
        b1.prog_enable = 1; b1.prog_advance = 1;
        b1.data_in = 3;
        tick();
        for (int s = 0; s < 5; s++) begin
            b1.data_in = 8'(8'h10 + s);
            tick();
            for (int i = 0; i < 16; i++) begin
                b1.data_in = (s == 1 && i == 0) ? 8'd7 : 8'((s + 1) % 5);
                tick();
            end
        end
        chk("u1_loaded", b1.loaded, 1);
        b1.prog_advance = 0; b1.prog_enable = 0;
        tick();
        chk("u1_start", b1.state, 3);
        chk("u1_start_out", b1.out, 8'h13);
        b1.step = 1; b1.in = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("u1_seq", b1.state, seq1[j]);
            chk("u1_fault", b1.fault, flt1[j]);
        end
        b1.step = 0;
        tick();
        chk("u1_fault_sticky", b1.fault, 1);
        b1.prog_enable = 1;
        tick();
        chk("u1_fault_clear", b1.fault, 0);
        chk("u1_forced_start", b1.state, 3);
        b1.prog_enable = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_fsm_table.md
# prog_fsm_table

Parametrised, runtime-programmable Moore state machine controller. It generalises the fixed-geometry programmable FSM to arbitrary state count, input width and output width. It adds a programmable start state, a step-enable gate, load-complete and overflow status, and detection of out-of-range transition targets. It sits between the chip-level pins (input nibble, data bus, programming strobes) and the output pins. It is loaded as a serial word stream and then free-runs one transition per enabled clock.

## Interface
- STATE_COUNT, default 8: number of states, 2..256; STATE_WIDTH = max(1, $clog2(STATE_COUNT)).
- IN_WIDTH, default 4: width of the input symbol; 2^IN_WIDTH transitions per state.
- OUT_WIDTH, default 8: width of the per-state output word, must be ≤ DATA_WIDTH.
- DATA_WIDTH, default 8: programming word width, must be ≥ STATE_WIDTH.
- clock, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- prog_enable, input, 1: programming mode; FSM frozen while high.
- prog_advance, input, 1: write strobe; one word accepted per clock it is high, valid only with prog_enable.
- data_in, input, DATA_WIDTH: programming word.
- in, input, IN_WIDTH: input symbol.
- step, input, 1: transition enable in run mode.
- state, output, STATE_WIDTH: current state register.
- out, output, OUT_WIDTH: output word of current state.
- loaded, output, 1: full table written since last programming entry.
- overflow, output, 1: sticky, write attempted past end of stream.
- fault, output, 1: sticky, transition target ≥ STATE_COUNT encountered.

## Operation
- Stream layout, TOTAL = 1 + STATE_COUNT*(1 + 2^IN_WIDTH) words, pointer ptr from 0:
  - Word 0: start state, low STATE_WIDTH bits.
  - Per state s, base = 1 + s*(1 + 2^IN_WIDTH): word base is the output word (low OUT_WIDTH bits). Word base+1+i is next state for input i (low STATE_WIDTH bits).
  - Upper data_in bits are ignored.
- Programming:
  - prog_enable low forces ptr = 0.
  - The rising edge of prog_enable (0 then 1 on consecutive clocks) clears loaded and overflow.
  - prog_enable=1 & prog_advance=1 & ptr<TOTAL: write the word and increment ptr. When ptr reaches TOTAL, loaded=1.
  - prog_enable=1 & prog_advance=1 & ptr==TOTAL: no write; overflow=1.
  - While prog_enable=1, state is forced to the current start register every clock, including the cycle that writes word 0.
- Run (prog_enable=0):
  - step=1: next = table[state][in]. If next < STATE_COUNT, state <= next; otherwise state <= start and fault <= 1.
  - step=0: hold.
  - Running with loaded=0 is legal and uses the current table contents.
- fault is cleared only by reset or prog_enable rising.
- out = output word of state, combinational from the state register and table flops; no input-to-output path.

## Timing
- Reset (reset=1 at an edge) sets:
  - state=0, start=0, ptr=0.
  - All table entries and output words to 0.
  - loaded=0, overflow=0, fault=0.
  - Hence out=0.
- Reset mid-stream aborts programming. The stream must restart from word 0 after prog_enable is re-asserted.
- A transition takes effect at the edge where step=1; state and out are updated 1 cycle after that sample.
- A written word is visible in the table the cycle after its write edge.
- loaded rises the cycle after the final word's write edge.
- prog_enable falling to 0: the first run transition can occur on the next edge with step=1, from the start state.
- Simultaneous prog_enable=1 and step=1: programming wins; step is ignored.
- Back-to-back prog_advance on every clock is supported at full rate, with no wait states.

## Test plan
- Reset: assert reset 2 cycles with all inputs random. Expect state=0, out=0, loaded=0, overflow=0, fault=0, and all table reads 0.
- Full load of a counter FSM (defaults, TOTAL=137):
  - Program start=2, out[s]=8'hA0+s, next[s][i]=(s+1)%8 for all i.
  - Expect loaded=1 after word 136. Drop prog_enable: out=8'hA2.
  - Apply 6 step cycles: state sequence 3,4,5,6,7,0, out=8'hA0 at end.
- Input-dependent branch: next[0][5]=6, next[0][other]=0, in=5, step=1. Expect state 0→6 in one cycle; with in=4, state stays 0.
- Step gating and simultaneity:
  - step=0 for 10 cycles: state unchanged.
  - prog_enable=1 with step=1: state forced to start; no transition.
- Overflow: write 140 words. Expect loaded=1 at word 137, overflow=1 from the first extra write, and table unchanged by the extra words. Re-entering programming clears both flags.
- Out-of-range target and mid-stream reset:
  - With STATE_COUNT=5, program next[1][0]=7 and step from state 1. Expect state=start, fault=1.
  - Separately, reset after 40 words: loaded=0, table all zero.
